// File: rtl/uart_tx_frame_if.sv
// Handshake and serial-line bundle of the parametrised UART frame transmitter.
// The system side (register/FIFO) is the master; the transmitter is the slave.
interface uart_tx_frame_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  STOP_2;
   logic                  MSB_FIRST;
   logic                  TX_OUT;
   logic                  Busy;
   logic                  TX_Done;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP_2, MSB_FIRST,
      input  TX_OUT, Busy, TX_Done
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP_2, MSB_FIRST,
      output TX_OUT, Busy, TX_Done
   );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start / DATA_WIDTH data / optional parity / 1-2 stop bits,
// each bit held BIT_CYCLES clocks, bit order chosen per frame.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8,
   parameter int BIT_CYCLES = 1
) (
   input logic            CLK,
   input logic            RST,
   uart_tx_frame_if.slave tx_if
);

   localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [TW-1:0] TMAX  = TW'(BIT_CYCLES - 1);
   // Timer value one cycle before the end of a bit; only meaningful when BIT_CYCLES > 1.
   localparam logic [TW-1:0] TDONE = TW'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         r[i] = d[DATA_WIDTH-1-i];
      end
      return r;
   endfunction

   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   state_t                state;
   logic [TW-1:0]         timer;
   logic [CW-1:0]         bit_cnt;
   logic                  stop_cnt;
   logic [DATA_WIDTH-1:0] shifter;
   logic                  par_en_s;
   logic                  par_bit_s;
   logic                  stop2_s;
   logic                  tx_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  wrap;

   assign wrap = (timer == TMAX);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         timer     <= '0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
         shifter   <= '0;
         par_en_s  <= 1'b0;
         par_bit_s <= 1'b0;
         stop2_s   <= 1'b0;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (state != IDLE) begin
            timer <= wrap ? '0 : timer + 1'b1;
         end
         case (state)
            IDLE: begin
               if (tx_if.Data_Valid) begin
                  // Pre-reverse for MSB-first so the data phase always shifts out bit 0.
                  shifter   <= tx_if.MSB_FIRST ? bit_reverse(tx_if.P_DATA) : tx_if.P_DATA;
                  par_en_s  <= tx_if.PAR_EN;
                  par_bit_s <= parity_of(tx_if.P_DATA, tx_if.PAR_TYP);
                  stop2_s   <= tx_if.STOP_2;
                  timer     <= '0;
                  bit_cnt   <= '0;
                  stop_cnt  <= 1'b0;
                  tx_r      <= 1'b0;
                  busy_r    <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (wrap) begin
                  tx_r    <= shifter[0];
                  shifter <= shifter >> 1;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (wrap) begin
                  if (bit_cnt != LAST_BIT) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx_r    <= shifter[0];
                     shifter <= shifter >> 1;
                  end else if (par_en_s) begin
                     tx_r  <= par_bit_s;
                     state <= PARITY;
                  end else begin
                     tx_r  <= 1'b1;
                     state <= STOP;
                     if (BIT_CYCLES == 1 && !stop2_s) begin
                        done_r <= 1'b1;
                     end
                  end
               end
            end
            PARITY: begin
               if (wrap) begin
                  tx_r  <= 1'b1;
                  state <= STOP;
                  if (BIT_CYCLES == 1 && !stop2_s) begin
                     done_r <= 1'b1;
                  end
               end
            end
            STOP: begin
               // TX_Done is registered, so it is raised one cycle ahead of the final stop cycle.
               if (wrap) begin
                  if (stop2_s && !stop_cnt) begin
                     stop_cnt <= 1'b1;
                     if (BIT_CYCLES == 1) begin
                        done_r <= 1'b1;
                     end
                  end else begin
                     busy_r <= 1'b0;
                     state  <= IDLE;
                  end
               end else if (BIT_CYCLES > 1 && timer == TDONE && (!stop2_s || stop_cnt)) begin
                  done_r <= 1'b1;
               end
            end
            default: begin
               tx_r   <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign tx_if.TX_OUT  = tx_r;
   assign tx_if.Busy    = busy_r;
   assign tx_if.TX_Done = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three instances (8b/1clk, 8b/4clk, 5b/1clk) checked
// every cycle against a frame-list model, plus literal expected bit streams.
module tb_uart_tx_frame;

   logic CLK;
   logic RST;
   int   checks;
   int   errors;

   uart_tx_frame_if #(.DATA_WIDTH(8)) if0 ();
   uart_tx_frame_if #(.DATA_WIDTH(8)) if1 ();
   uart_tx_frame_if #(.DATA_WIDTH(5)) if2 ();

   uart_tx_frame #(.DATA_WIDTH(8), .BIT_CYCLES(1)) dut0 (.CLK(CLK), .RST(RST), .tx_if(if0));
   uart_tx_frame #(.DATA_WIDTH(8), .BIT_CYCLES(4)) dut1 (.CLK(CLK), .RST(RST), .tx_if(if1));
   uart_tx_frame #(.DATA_WIDTH(5), .BIT_CYCLES(1)) dut2 (.CLK(CLK), .RST(RST), .tx_if(if2));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic tx_of(input int id);
      case (id)
         0:       return if0.TX_OUT;
         1:       return if1.TX_OUT;
         default: return if2.TX_OUT;
      endcase
   endfunction

   function automatic logic busy_of(input int id);
      case (id)
         0:       return if0.Busy;
         1:       return if1.Busy;
         default: return if2.Busy;
      endcase
   endfunction

   function automatic logic done_of(input int id);
      case (id)
         0:       return if0.TX_Done;
         1:       return if1.TX_Done;
         default: return if2.TX_Done;
      endcase
   endfunction

   // ---------------- model: frame bit list plus position inside the frame
   int   m_dw [3] = '{8, 8, 5};
   int   m_bc [3] = '{1, 4, 1};
   int   m_c  [3] = '{0, 0, 0};
   int   m_f  [3] = '{0, 0, 0};
   logic m_bits [3][16];

   task automatic model_step(input int id, input logic r, input logic dv, input logic [8:0] d,
                             input logic pe, input logic typ, input logic s2, input logic msb);
      int   n;
      logic par;
      if (r) begin
         m_c[id] = 0;
      end else if (m_c[id] != 0) begin
         m_c[id] = (m_c[id] == m_f[id] * m_bc[id]) ? 0 : m_c[id] + 1;
      end else if (dv) begin
         n = 0;
         par = typ;
         m_bits[id][n] = 1'b0; n++;
         for (int j = 0; j < m_dw[id]; j++) begin
            m_bits[id][n] = msb ? d[m_dw[id]-1-j] : d[j];
            par = par ^ d[j];
            n++;
         end
         if (pe) begin m_bits[id][n] = par; n++; end
         m_bits[id][n] = 1'b1; n++;
         if (s2) begin m_bits[id][n] = 1'b1; n++; end
         m_f[id] = n;
         m_c[id] = 1;
      end
   endtask

   always @(posedge CLK) begin
      model_step(0, RST, if0.Data_Valid, 9'(if0.P_DATA), if0.PAR_EN, if0.PAR_TYP, if0.STOP_2, if0.MSB_FIRST);
      model_step(1, RST, if1.Data_Valid, 9'(if1.P_DATA), if1.PAR_EN, if1.PAR_TYP, if1.STOP_2, if1.MSB_FIRST);
      model_step(2, RST, if2.Data_Valid, 9'(if2.P_DATA), if2.PAR_EN, if2.PAR_TYP, if2.STOP_2, if2.MSB_FIRST);
   end

   always @(negedge CLK) begin
      for (int id = 0; id < 3; id++) begin
         logic etx, ebusy, edone;
         if (m_c[id] == 0) begin
            etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
         end else begin
            etx   = m_bits[id][(m_c[id] - 1) / m_bc[id]];
            ebusy = 1'b1;
            edone = (m_c[id] == m_f[id] * m_bc[id]);
         end
         check($sformatf("model_tx%0d@%0t", id, $time), 64'(tx_of(id)), 64'(etx));
         check($sformatf("model_busy%0d@%0t", id, $time), 64'(busy_of(id)), 64'(ebusy));
         check($sformatf("model_done%0d@%0t", id, $time), 64'(done_of(id)), 64'(edone));
      end
   end

   // ---------------- stimulus
   task automatic collect(input int id, input int n, output logic [0:63] txs,
                          output int bcnt, output int dcnt, output int dpos);
      txs  = '0;
      bcnt = 0;
      dcnt = 0;
      dpos = -1;
      for (int i = 0; i < n; i++) begin
         txs[i] = tx_of(id);
         if (busy_of(id)) bcnt++;
         if (done_of(id)) begin dcnt++; dpos = i; end
         @(negedge CLK);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   logic [0:63] txs;
   logic [0:63] ev;
   int          bcnt, dcnt, dpos, bcnt2, dcnt2, dpos2;
   logic [0:11] e2;
   logic [0:11] e3;
   logic [0:7]  p4;
   logic [0:11] e6;

   initial begin
      checks = 0;
      errors = 0;
      e2 = 12'b0101_0010_1011;
      e3 = 12'b0101_0010_1111;
      p4 = 8'b0110_0111;
      e6 = 12'b0001_1110_0111;
      RST = 1'b1;
      if0.P_DATA = '0; if0.Data_Valid = 0; if0.PAR_EN = 0; if0.PAR_TYP = 0; if0.STOP_2 = 0; if0.MSB_FIRST = 0;
      if1.P_DATA = '0; if1.Data_Valid = 0; if1.PAR_EN = 0; if1.PAR_TYP = 0; if1.STOP_2 = 0; if1.MSB_FIRST = 0;
      if2.P_DATA = '0; if2.Data_Valid = 0; if2.PAR_EN = 0; if2.PAR_TYP = 0; if2.STOP_2 = 0; if2.MSB_FIRST = 0;

      // reset and idle
      idle_cycles(3);
      RST = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("idle_tx", 64'(if0.TX_OUT), 64'd1);
         check("idle_busy", 64'(if0.Busy | if1.Busy | if2.Busy), 64'd0);
         check("idle_done", 64'(if0.TX_Done | if1.TX_Done | if2.TX_Done), 64'd0);
         @(negedge CLK);
      end

      // A5, LSB first, even parity, one stop, 1 clk/bit
      if0.P_DATA = 8'hA5; if0.PAR_EN = 1; if0.PAR_TYP = 0; if0.STOP_2 = 0; if0.MSB_FIRST = 0;
      if0.Data_Valid = 1;
      @(negedge CLK);
      if0.Data_Valid = 0;
      collect(0, 12, txs, bcnt, dcnt, dpos);
      ev = '0; ev[0:11] = e2;
      check("a5_even_stream", txs, ev);
      check("a5_even_busy", 64'(bcnt), 64'd11);
      check("a5_even_done_cnt", 64'(dcnt), 64'd1);
      check("a5_even_done_pos", 64'(dpos), 64'd10);
      idle_cycles(2);

      // A5, MSB first, odd parity, two stops, 4 clk/bit
      if1.P_DATA = 8'hA5; if1.PAR_EN = 1; if1.PAR_TYP = 1; if1.STOP_2 = 1; if1.MSB_FIRST = 1;
      if1.Data_Valid = 1;
      @(negedge CLK);
      if1.Data_Valid = 0;
      collect(1, 49, txs, bcnt, dcnt, dpos);
      ev = '0;
      for (int i = 0; i < 48; i++) ev[i] = e3[i / 4];
      ev[48] = 1'b1;
      check("a5_odd_msb_stream", txs, ev);
      check("a5_odd_msb_busy", 64'(bcnt), 64'd48);
      check("a5_odd_msb_done_pos", 64'(dpos), 64'd47);
      idle_cycles(2);

      // 5-bit 13h back-to-back, Data_Valid held high for three frames
      if2.P_DATA = 5'h13; if2.PAR_EN = 0; if2.PAR_TYP = 0; if2.STOP_2 = 0; if2.MSB_FIRST = 0;
      if2.Data_Valid = 1;
      @(negedge CLK);
      collect(2, 23, txs, bcnt, dcnt, dpos);
      if2.Data_Valid = 0;
      ev = '0;
      for (int i = 0; i < 23; i++) ev[i] = p4[i % 8];
      check("b2b_stream", txs, ev);
      check("b2b_busy", 64'(bcnt), 64'd21);
      collect(2, 5, txs, bcnt2, dcnt2, dpos2);
      ev = '0; ev[0:4] = 5'b11111;
      check("b2b_tail_idle", txs, ev);
      check("b2b_tail_busy", 64'(bcnt2), 64'd0);
      check("b2b_done_cnt", 64'(dcnt + dcnt2), 64'd3);

      // inputs disturbed mid-frame
      if0.P_DATA = 8'hA5; if0.PAR_EN = 1; if0.PAR_TYP = 0; if0.STOP_2 = 0; if0.MSB_FIRST = 0;
      if0.Data_Valid = 1;
      @(negedge CLK);
      if0.Data_Valid = 0;
      txs = '0; bcnt = 0; dcnt = 0;
      for (int i = 0; i < 18; i++) begin
         txs[i] = if0.TX_OUT;
         if (if0.Busy) bcnt++;
         if (if0.TX_Done) dcnt++;
         if (i == 2) begin
            if0.Data_Valid = 1; if0.P_DATA = 8'h3C; if0.PAR_EN = 0; if0.MSB_FIRST = 1; if0.STOP_2 = 1;
         end
         if (i == 5) if0.Data_Valid = 0;
         @(negedge CLK);
      end
      ev = '0; ev[0:11] = e2;
      for (int i = 12; i < 18; i++) ev[i] = 1'b1;
      check("midframe_stream", txs, ev);
      check("midframe_busy", 64'(bcnt), 64'd11);
      check("midframe_done_cnt", 64'(dcnt), 64'd1);
      if0.PAR_EN = 1; if0.MSB_FIRST = 0; if0.STOP_2 = 0; if0.P_DATA = 8'hA5;
      idle_cycles(2);

      // reset during the 4th data bit, then a fresh frame
      if0.Data_Valid = 1;
      @(negedge CLK);
      if0.Data_Valid = 0;
      idle_cycles(4);
      RST = 1'b1;
      @(negedge CLK);
      check("abort_tx", 64'(if0.TX_OUT), 64'd1);
      check("abort_busy", 64'(if0.Busy), 64'd0);
      check("abort_done", 64'(if0.TX_Done), 64'd0);
      RST = 1'b0;
      idle_cycles(2);
      if0.P_DATA = 8'h3C; if0.PAR_EN = 1; if0.PAR_TYP = 1; if0.STOP_2 = 1; if0.MSB_FIRST = 0;
      if0.Data_Valid = 1;
      @(negedge CLK);
      if0.Data_Valid = 0;
      collect(0, 13, txs, bcnt, dcnt, dpos);
      ev = '0; ev[0:11] = e6; ev[12] = 1'b1;
      check("post_reset_stream", txs, ev);
      check("post_reset_busy", 64'(bcnt), 64'd12);
      check("post_reset_done_pos", 64'(dpos), 64'd11);
      idle_cycles(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
